// File: rtl/axil_regbank_slave.sv
// axil_regbank_slave
// AXI4-Lite slave register bank. Write address and write data are each captured
// into a one-deep holding buffer and committed together once both are present and
// the B channel is free. Reads complete with one cycle of latency.
//
// Optional build macro: REGBANK_WCOUNT_EN
//   When defined, index NUM_REGS is a read-only counter of OKAY write commits.
//   When undefined, that index decodes as out-of-range like any other.
//
// Ports:
//   s3_axi_aclk, s3_axi_areset    clock, synchronous active-high reset
//   s3_axi_aw*                    write address channel
//   s3_axi_w*                     write data channel (with byte strobes)
//   s3_axi_b*                     write response channel
//   s3_axi_ar*                    read address channel
//   s3_axi_r*                     read data channel
//   reg_out                       flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse                      one-cycle pulse per register on an OKAY commit
module axil_regbank_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_REGS   = 8,
   parameter int RESP_WIDTH = 2
) (
   input  logic                           s3_axi_aclk,
   input  logic                           s3_axi_areset,
   input  logic [ADDR_WIDTH-1:0]          s3_axi_awaddr,
   input  logic                           s3_axi_awvalid,
   output logic                           s3_axi_awready,
   input  logic [DATA_WIDTH-1:0]          s3_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s3_axi_wstrb,
   input  logic                           s3_axi_wvalid,
   output logic                           s3_axi_wready,
   output logic [RESP_WIDTH-1:0]          s3_axi_bresp,
   output logic                           s3_axi_bvalid,
   input  logic                           s3_axi_bready,
   input  logic [ADDR_WIDTH-1:0]          s3_axi_araddr,
   input  logic                           s3_axi_arvalid,
   output logic                           s3_axi_arready,
   output logic [DATA_WIDTH-1:0]          s3_axi_rdata,
   output logic [RESP_WIDTH-1:0]          s3_axi_rresp,
   output logic                           s3_axi_rvalid,
   input  logic                           s3_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int IDX_WIDTH  = ADDR_WIDTH - 2;

   localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
   localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

   // Holding buffers
   logic                  aw_held_q;
   logic [IDX_WIDTH-1:0]  aw_idx_q;
   logic                  w_held_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_WIDTH-1:0] w_strb_q;

   // Response state
   logic                  bvalid_q;
   logic [RESP_WIDTH-1:0] bresp_q;
   logic                  rvalid_q;
   logic [RESP_WIDTH-1:0] rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]   wr_pulse_q;

   logic                  aw_fire;
   logic                  w_fire;
   logic                  ar_fire;
   logic                  commit;
   logic [NUM_REGS-1:0]   wr_sel;
   logic                  wr_hit;
   logic [IDX_WIDTH-1:0]  ar_idx;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_hit;

   // Byte offset bits are ignored: unaligned addresses alias to their word.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{s3_axi_awaddr[1:0], s3_axi_araddr[1:0]};

`ifdef REGBANK_WCOUNT_EN
   logic [DATA_WIDTH-1:0] wcount_q;
`endif

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   assign s3_axi_awready = !aw_held_q;
   assign s3_axi_wready  = !w_held_q;
   assign s3_axi_arready = !rvalid_q || s3_axi_rready;

   assign aw_fire = s3_axi_awvalid && !aw_held_q;
   assign w_fire  = s3_axi_wvalid && !w_held_q;
   assign ar_fire = s3_axi_arvalid && s3_axi_arready;

   // Commit may proceed when B is empty or is being drained on this very edge.
   assign commit  = aw_held_q && w_held_q && (!bvalid_q || s3_axi_bready);

   assign ar_idx  = s3_axi_araddr[ADDR_WIDTH-1:2];

   // ------------------------------------------------------------------
   // Address decode. The counter index never appears in wr_sel, so writes to
   // it fall through to SLVERR.
   // ------------------------------------------------------------------
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (aw_idx_q == IDX_WIDTH'(i)) begin
            wr_sel[i] = 1'b1;
         end
      end
   end

   assign wr_hit = |wr_sel;

   always_comb begin
      rd_data = '0;
      rd_hit  = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ar_idx == IDX_WIDTH'(i)) begin
            rd_data = regs_q[i];
            rd_hit  = 1'b1;
         end
      end
`ifdef REGBANK_WCOUNT_EN
      if (ar_idx == IDX_WIDTH'(NUM_REGS)) begin
         rd_data = wcount_q;
         rd_hit  = 1'b1;
      end
`endif
   end

   // ------------------------------------------------------------------
   // Write address / data holding buffers
   // ------------------------------------------------------------------
   always_ff @(posedge s3_axi_aclk) begin
      if (s3_axi_areset) begin
         aw_held_q <= 1'b0;
         aw_idx_q  <= '0;
      end else if (aw_fire) begin
         aw_held_q <= 1'b1;
         aw_idx_q  <= s3_axi_awaddr[ADDR_WIDTH-1:2];
      end else if (commit) begin
         aw_held_q <= 1'b0;
      end
   end

   always_ff @(posedge s3_axi_aclk) begin
      if (s3_axi_areset) begin
         w_held_q <= 1'b0;
         w_data_q <= '0;
         w_strb_q <= '0;
      end else if (w_fire) begin
         w_held_q <= 1'b1;
         w_data_q <= s3_axi_wdata;
         w_strb_q <= s3_axi_wstrb;
      end else if (commit) begin
         w_held_q <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Register array and write pulses
   // ------------------------------------------------------------------
   always_ff @(posedge s3_axi_aclk) begin
      if (s3_axi_areset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (commit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_sel[i]) begin
               for (int b = 0; b < STRB_WIDTH; b++) begin
                  if (w_strb_q[b]) begin
                     regs_q[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   // A zero-strobe commit still pulses: the pulse marks the transaction, not a data change.
   always_ff @(posedge s3_axi_aclk) begin
      if (s3_axi_areset) begin
         wr_pulse_q <= '0;
      end else begin
         wr_pulse_q <= commit ? wr_sel : '0;
      end
   end

`ifdef REGBANK_WCOUNT_EN
   always_ff @(posedge s3_axi_aclk) begin
      if (s3_axi_areset) begin
         wcount_q <= '0;
      end else if (commit && wr_hit) begin
         wcount_q <= wcount_q + 1'b1;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Write response. A commit on the draining edge keeps bvalid high with the
   // new response.
   // ------------------------------------------------------------------
   always_ff @(posedge s3_axi_aclk) begin
      if (s3_axi_areset) begin
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else if (commit) begin
         bvalid_q <= 1'b1;
         bresp_q  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (s3_axi_bready) begin
         bvalid_q <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Read channel. rd_data samples regs_q before any same-edge commit lands,
   // so a colliding read returns the pre-write value.
   // ------------------------------------------------------------------
   always_ff @(posedge s3_axi_aclk) begin
      if (s3_axi_areset) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (ar_fire) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_data;
         rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (s3_axi_rready) begin
         rvalid_q <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign s3_axi_bvalid = bvalid_q;
   assign s3_axi_bresp  = bresp_q;
   assign s3_axi_rvalid = rvalid_q;
   assign s3_axi_rdata  = rdata_q;
   assign s3_axi_rresp  = rresp_q;
   assign wr_pulse      = wr_pulse_q;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
      assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
   end

endmodule

// File: tb/tb_axil_regbank_slave.sv
module tb_axil_regbank_slave;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int NR = 8;

   logic          clk = 1'b0;
   logic          areset;
   logic [AW-1:0] awaddr;
   logic          awvalid;
   logic          awready;
   logic [DW-1:0] wdata;
   logic [3:0]    wstrb;
   logic          wvalid;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;
   logic [AW-1:0] araddr;
   logic          arvalid;
   logic          arready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready;
   logic [NR*DW-1:0] reg_out;
   logic [NR-1:0]    wr_pulse;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model
   logic [31:0] mreg [NR];
   logic [31:0] mcount;

   always #5 clk = ~clk;

   axil_regbank_slave dut (
      .s3_axi_aclk    (clk),
      .s3_axi_areset  (areset),
      .s3_axi_awaddr  (awaddr),
      .s3_axi_awvalid (awvalid),
      .s3_axi_awready (awready),
      .s3_axi_wdata   (wdata),
      .s3_axi_wstrb   (wstrb),
      .s3_axi_wvalid  (wvalid),
      .s3_axi_wready  (wready),
      .s3_axi_bresp   (bresp),
      .s3_axi_bvalid  (bvalid),
      .s3_axi_bready  (bready),
      .s3_axi_araddr  (araddr),
      .s3_axi_arvalid (arvalid),
      .s3_axi_arready (arready),
      .s3_axi_rdata   (rdata),
      .s3_axi_rresp   (rresp),
      .s3_axi_rvalid  (rvalid),
      .s3_axi_rready  (rready),
      .reg_out        (reg_out),
      .wr_pulse       (wr_pulse)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] model_flat();
      logic [255:0] f;
      for (int i = 0; i < NR; i++) f[i*32 +: 32] = mreg[i];
      return f;
   endfunction

   // Apply a write to the model; returns the expected response and pulse vector.
   task automatic model_write(input logic [7:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [1:0] resp,
                              output logic [7:0] pulse);
      int idx;
      idx = int'(addr) / 4;
      if (idx < NR) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) mreg[idx][b*8 +: 8] = data[b*8 +: 8];
         resp   = 2'd0;
         pulse  = 8'(1 << idx);
         mcount = mcount + 32'd1;
      end else begin
         resp  = 2'd2;
         pulse = 8'd0;
      end
   endtask

   task automatic model_read(input logic [7:0] addr, output logic [31:0] data,
                             output logic [1:0] resp);
      int idx;
      idx = int'(addr) / 4;
      data = 32'd0;
      resp = 2'd2;
      if (idx < NR) begin
         data = mreg[idx];
         resp = 2'd0;
      end
`ifdef REGBANK_WCOUNT_EN
      if (idx == NR) begin
         data = mcount;
         resp = 2'd0;
      end
`endif
   endtask

   // Called at a negedge with bready=1 and both write channels free.
   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output logic [7:0] pulse);
      int n;
      awaddr = addr; awvalid = 1'b1;
      wdata = data; wstrb = strb; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("b_arrives", bvalid, 1'b1);
      resp = bresp;
      pulse = wr_pulse;
      @(negedge clk);
   endtask

   // Called at a negedge with rready=1 and no read pending.
   task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      araddr = addr; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      chk("r_latency", rvalid, 1'b1);
      data = rdata;
      resp = rresp;
      @(negedge clk);
   endtask

   task automatic write_check(input string tag, input logic [7:0] addr,
                              input logic [31:0] data, input logic [3:0] strb);
      logic [1:0] r, er;
      logic [7:0] p, ep;
      axi_write(addr, data, strb, r, p);
      model_write(addr, data, strb, er, ep);
      chk({tag, "_bresp"}, r, er);
      chk({tag, "_pulse"}, p, ep);
   endtask

   task automatic read_check(input string tag, input logic [7:0] addr);
      logic [31:0] d, ed;
      logic [1:0]  r, er;
      axi_read(addr, d, r);
      model_read(addr, ed, er);
      chk({tag, "_rdata"}, d, ed);
      chk({tag, "_rresp"}, r, er);
   endtask

   // Write commit and AR accept land on the same edge; read must see old value.
   task automatic collide(input string tag, input logic [7:0] waddr,
                          input logic [31:0] data, input logic [7:0] raddr);
      logic [31:0] ed;
      logic [1:0]  er, wr;
      logic [7:0]  wp;
      model_read(raddr, ed, er);
      awaddr = waddr; awvalid = 1'b1; wdata = data; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = raddr; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      chk({tag, "_bvalid"}, bvalid, 1'b1);
      chk({tag, "_rvalid"}, rvalid, 1'b1);
      chk({tag, "_rdata_old"}, rdata, ed);
      model_write(waddr, data, 4'hF, wr, wp);
      chk({tag, "_bresp"}, bresp, wr);
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d1, d2, old3;
      logic [7:0]  a;
      logic [7:0]  addrs [8];
      logic [1:0]  er;
      logic [7:0]  ep;
      logic [31:0] ed;

      areset = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
      for (int i = 0; i < NR; i++) mreg[i] = 32'd0;
      mcount = 32'd0;

      // Reset
      repeat (2) @(negedge clk);
      chk("rst_awready", awready, 1'b1);
      chk("rst_wready", wready, 1'b1);
      chk("rst_arready", arready, 1'b1);
      chk("rst_bvalid", bvalid, 1'b0);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_reg_out", reg_out, 256'd0);
      chk("rst_wr_pulse", wr_pulse, 8'd0);
      areset = 1'b0;
      @(negedge clk);

      // AW and W in the same cycle, with latency checks
      awaddr = 8'h04; awvalid = 1'b1; wdata = 32'h22; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("same_b_not_early", bvalid, 1'b0);
      chk("same_awready_held", awready, 1'b0);
      @(negedge clk);
      model_write(8'h04, 32'h22, 4'hF, er, ep);
      chk("same_bvalid", bvalid, 1'b1);
      chk("same_bresp", bresp, er);
      chk("same_pulse", wr_pulse, ep);
      @(negedge clk);
      chk("same_pulse_gone", wr_pulse, 8'd0);
      chk("same_b_done", bvalid, 1'b0);
      read_check("same_rd", 8'h04);

      // W first, AW three cycles later
      write_check("pre2", 8'h08, 32'h11223344, 4'hF);
      wdata = 32'hA5A5A5A5; wstrb = 4'h5; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("wfirst_wready_low", wready, 1'b0);
         chk("wfirst_no_b", bvalid, 1'b0);
         @(negedge clk);
      end
      awaddr = 8'h08; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      chk("wfirst_wready_low2", wready, 1'b0);
      @(negedge clk);
      model_write(8'h08, 32'hA5A5A5A5, 4'h5, er, ep);
      chk("wfirst_bvalid", bvalid, 1'b1);
      chk("wfirst_bresp", bresp, er);
      chk("wfirst_wready_back", wready, 1'b1);
      chk("wfirst_reg2", reg_out[95:64], 32'h11A533A5);
      chk("wfirst_flat", reg_out, model_flat());
      @(negedge clk);

      // Out-of-range write and read
      write_check("oor_wr", 8'h24, $urandom, 4'hF);
      chk("oor_flat", reg_out, model_flat());
      read_check("oor_rd_24", 8'h24);
      read_check("idx8_rd", 8'h20);

      // B backpressure with a second pair buffered
      bready = 1'b0;
      d1 = $urandom; d2 = $urandom;
      awaddr = 8'h0C; awvalid = 1'b1; wdata = d1; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      model_write(8'h0C, d1, 4'hF, er, ep);
      chk("bp_first_bvalid", bvalid, 1'b1);
      chk("bp_first_pulse", wr_pulse, ep);
      chk("bp_awready_free", awready, 1'b1);
      awaddr = 8'h10; awvalid = 1'b1; wdata = d2; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_awready_held", awready, 1'b0);
         chk("bp_wready_held", wready, 1'b0);
         chk("bp_bvalid_held", bvalid, 1'b1);
         chk("bp_no_pulse", wr_pulse, 8'd0);
         chk("bp_no_commit", reg_out, model_flat());
         @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      model_write(8'h10, d2, 4'hF, er, ep);
      chk("bp_second_bvalid", bvalid, 1'b1);
      chk("bp_second_bresp", bresp, er);
      chk("bp_second_pulse", wr_pulse, ep);
      chk("bp_second_flat", reg_out, model_flat());
      @(negedge clk);
      chk("bp_b_done", bvalid, 1'b0);

      // R backpressure, then a queued read completing on release
      rready = 1'b0;
      araddr = 8'h0C; arvalid = 1'b1;
      @(negedge clk);
      araddr = 8'h04;
      model_read(8'h0C, ed, er);
      for (int i = 0; i < 4; i++) begin
         chk("rbp_rvalid", rvalid, 1'b1);
         chk("rbp_rdata_stable", rdata, ed);
         chk("rbp_arready_low", arready, 1'b0);
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      model_read(8'h04, ed, er);
      chk("rbp_next_rvalid", rvalid, 1'b1);
      chk("rbp_next_rdata", rdata, ed);
      @(negedge clk);
      chk("rbp_idle", rvalid, 1'b0);

      // Same-edge write commit and read of the same register (unaligned read addr)
      old3 = $urandom;
      collide("coll", 8'h14, old3, 8'h15);
      read_check("coll_after", 8'h14);

      // Random writes against the model
      for (int i = 0; i < 24; i++) begin
         a = 8'($urandom_range(0, 39));
         write_check("rnd_wr", a, $urandom, 4'($urandom_range(0, 15)));
      end
      chk("rnd_flat", reg_out, model_flat());

      // Back-to-back reads at one per cycle
      for (int i = 0; i < 8; i++) addrs[i] = 8'($urandom_range(0, 47));
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            model_read(addrs[i-1], ed, er);
            chk("b2b_rvalid", rvalid, 1'b1);
            chk("b2b_rdata", rdata, ed);
            chk("b2b_rresp", rresp, er);
         end
         if (i < 8) begin
            araddr = addrs[i]; arvalid = 1'b1;
         end else begin
            arvalid = 1'b0;
         end
         @(negedge clk);
      end
      chk("b2b_idle", rvalid, 1'b0);

`ifdef REGBANK_WCOUNT_EN
      read_check("cnt_rd", 8'h20);
      write_check("cnt_wr", 8'h20, 32'hFFFFFFFF, 4'hF);
      read_check("cnt_rd_after", 8'h20);
      collide("cnt_coll", 8'h00, $urandom, 8'h20);
      read_check("cnt_rd_post", 8'h20);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
